// File: rtl/jericalla_secuenciador.sv
// -----------------------------------------------------------------------------
// jericalla_secuenciador
//
// Issue controller for the two-buffer Jericalla pipeline. It walks the external
// combinational instruction ROM, drives the datapath instruction bus, and
// inserts NOP bubbles whenever a candidate reads a register that one of the two
// instructions still in flight is going to write. The pipeline has no
// forwarding, so this is the only RAW protection. Once the last instruction has
// issued, it drains the pipeline with NOPs and pulses done.
//
// Ports
//   clk          pipeline clock (shared with BUFFER_1/BUFFER_2)
//   rst_n        asynchronous active-low reset
//   start        one-cycle pulse; starts a run from address 0 (ignored when busy)
//   prog_len     number of instructions to run, sampled on an accepted start
//   imem_addr    ROM address, taken straight from the pc register
//   imem_data    ROM data for imem_addr, valid in the same cycle
//   instruccion  registered instruction to the datapath
//                [17:15] op, [14:10] WA, [9:5] RA1, [4:0] RA2
//   busy         high from an accepted start until the end of the done pulse
//   done         one-cycle completion pulse
//   bubble_cnt   bubbles inserted during the current/last run, saturating
// -----------------------------------------------------------------------------
module jericalla_secuenciador #(
    parameter int unsigned PC_W           = 8,
    parameter logic [17:0] NOP_INSTR      = 18'h00000,
    parameter logic [7:0]  WRITES_BR_MASK = 8'b0000_0110,
    parameter int unsigned DRAIN_CYC      = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [PC_W-1:0] prog_len,
    output logic [PC_W-1:0] imem_addr,
    input  logic [17:0]     imem_data,
    output logic [17:0]     instruccion,
    output logic            busy,
    output logic            done,
    output logic [15:0]     bubble_cnt
);

    // Drain counter only has to reach DRAIN_CYC-1. A DRAIN_CYC of 0 still
    // issues a single NOP before DONE.
    localparam int unsigned      DRN_W    = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((DRAIN_CYC == 0) ? 0 : DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  len_q, len_d;
    logic [17:0]      instr_q, instr_d;   // also serves as hist1
    logic [17:0]      hist2_q, hist2_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [15:0]      bcnt_q, bcnt_d;
    logic [DRN_W-1:0] drn_q, drn_d;
    logic             hz;

    // True when in-flight instruction h will write a register that candidate c
    // reads. Register 0 gets no special treatment.
    function automatic logic raw_hz(input logic [17:0] h, input logic [17:0] c);
        return WRITES_BR_MASK[h[17:15]] &&
               ((h[14:10] == c[9:5]) || (h[14:10] == c[4:0]));
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        instr_d = NOP_INSTR;
        hist2_d = instr_q;            // history shifts on every edge, NOPs included
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcnt_d  = bcnt_q;
        drn_d   = drn_q;
        hz      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = prog_len;
                    pc_d    = '0;
                    bcnt_d  = '0;
                    drn_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (prog_len == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                hz = raw_hz(instr_q, imem_data) || raw_hz(hist2_q, imem_data);
                if (hz) begin
                    if (bcnt_q != 16'hFFFF) begin
                        bcnt_d = bcnt_q + 16'd1;
                    end
                end else begin
                    instr_d = imem_data;
                    pc_d    = pc_q + PC_W'(1);
                    // prog_len never exceeds 2^PC_W-1, so pc+1 cannot wrap here.
                    if ((pc_q + PC_W'(1)) == len_q) begin
                        drn_d   = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drn_q >= DRN_LAST) begin
                    drn_d   = '0;
                    state_d = S_DONE;
                end else begin
                    drn_d = drn_q + DRN_W'(1);
                end
            end
            S_DONE: begin
                // First edge raises done; the next one drops done and busy together.
                if (!done_q) begin
                    done_d = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            instr_q <= NOP_INSTR;
            hist2_q <= NOP_INSTR;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcnt_q  <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            instr_q <= instr_d;
            hist2_q <= hist2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcnt_q  <= bcnt_d;
            drn_q   <= drn_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instruccion = instr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign bubble_cnt  = bcnt_q;

endmodule
